// File: rtl/instr_decode_stage.sv
// Decode stage feeding the 8x8 register file and execute.
// Read addresses go out combinationally so the register file's registered
// A/B outputs line up with the registered control bundle. Load-use hazards
// insert a one-cycle bubble, and HALT is absorbing until reset.
module instr_decode_stage #(
    parameter int IW = 16,
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr_in,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [AW-1:0] RA,
    output logic [AW-1:0] RB,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [AW-1:0] dec_rd,
    output logic [2:0]    dec_alu_op,
    output logic [DW-1:0] dec_imm,
    output logic          dec_use_imm,
    output logic          dec_reg_write,
    output logic          dec_mem_read,
    output logic          dec_mem_write,
    output logic          dec_branch,
    output logic          halted,
    output logic          illegal
);
    typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    state_t        state_q, state_d;
    logic          dec_valid_q, dec_valid_d;
    logic [AW-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [DW-1:0] imm_q, imm_d;
    logic          use_imm_q, use_imm_d, reg_write_q, reg_write_d;
    logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic          branch_q, branch_d, halted_q, halted_d, illegal_q, illegal_d;

    // Instruction fields and decoded view of instr_in
    logic [3:0]           f_op;
    logic [AW-1:0]        f_rd, f_ra, f_rb;
    logic signed [5:0]    f_imm6;
    logic signed [DW-1:0] imm_ext;
    logic [AW-1:0]        n_rd;
    logic [2:0]           n_alu_op;
    logic [DW-1:0]        n_imm;
    logic                 n_use_imm, n_reg_write, n_mem_read, n_mem_write;
    logic                 n_branch, n_illegal, n_uses_rb, n_halt;
    logic                 adv, hazard, accept;

    assign f_op    = instr_in[15:12];
    assign f_rd    = instr_in[11:9];
    assign f_ra    = instr_in[8:6];
    assign f_rb    = instr_in[5:3];
    assign f_imm6  = instr_in[5:0];
    assign imm_ext = {{(DW-6){f_imm6[5]}}, f_imm6};

    // Decode the incoming opcode into a control bundle; NOP/illegal stay all-zero
    always_comb begin
        n_rd        = '0;
        n_alu_op    = ALU_ADD;
        n_imm       = '0;
        n_use_imm   = 1'b0;
        n_reg_write = 1'b0;
        n_mem_read  = 1'b0;
        n_mem_write = 1'b0;
        n_branch    = 1'b0;
        n_illegal   = 1'b0;
        n_uses_rb   = 1'b0;
        n_halt      = 1'b0;
        case (f_op)
            4'h0: ;
            4'h1, 4'h2, 4'h3, 4'h4: begin
                n_rd        = f_rd;
                n_uses_rb   = 1'b1;
                n_reg_write = (f_rd != '0);
                case (f_op)
                    4'h2:    n_alu_op = ALU_SUB;
                    4'h3:    n_alu_op = ALU_AND;
                    4'h4:    n_alu_op = ALU_OR;
                    default: n_alu_op = ALU_ADD;
                endcase
            end
            4'h5, 4'h6: begin
                n_rd        = f_rd;
                n_imm       = imm_ext;
                n_use_imm   = 1'b1;
                n_reg_write = (f_rd != '0);
                n_mem_read  = (f_op == 4'h6);
            end
            4'h7: begin
                n_imm       = imm_ext;
                n_use_imm   = 1'b1;
                n_mem_write = 1'b1;
                n_uses_rb   = 1'b1;
            end
            4'h8: begin
                n_imm     = imm_ext;
                n_alu_op  = ALU_SUB;
                n_branch  = 1'b1;
                n_uses_rb = 1'b1;
            end
            4'hF:    n_halt    = 1'b1;
            default: n_illegal = 1'b1;
        endcase
    end

    // A load in execute whose destination is read by instr_in must bubble once
    assign hazard = dec_valid_q & mem_read_q & (rd_q != '0) &
                    ((f_ra == rd_q) | (n_uses_rb & (f_rb == rd_q)));
    assign adv         = !dec_valid_q | dec_ready;
    assign instr_ready = (state_q == S_RUN) & adv & !hazard;
    assign accept      = instr_valid & instr_ready;
    assign RA          = accept ? f_ra : ra_q;
    assign RB          = accept ? f_rb : rb_q;

    // Next-state: accept loads the bundle, hazard bubbles, backpressure holds
    always_comb begin
        state_d     = state_q;
        dec_valid_d = dec_valid_q;
        rd_d        = rd_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        alu_op_d    = alu_op_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        branch_d    = branch_q;
        halted_d    = halted_q;
        illegal_d   = 1'b0;
        if (state_q == S_STALL) begin
            state_d = S_RUN;
        end
        if (accept && n_halt) begin
            dec_valid_d = 1'b0;
            state_d     = S_HALT;
            halted_d    = 1'b1;
        end else if (accept) begin
            dec_valid_d = 1'b1;
            rd_d        = n_rd;
            ra_d        = f_ra;
            rb_d        = f_rb;
            alu_op_d    = n_alu_op;
            imm_d       = n_imm;
            use_imm_d   = n_use_imm;
            reg_write_d = n_reg_write;
            mem_read_d  = n_mem_read;
            mem_write_d = n_mem_write;
            branch_d    = n_branch;
            illegal_d   = n_illegal;
        end else if ((state_q == S_RUN) && hazard && instr_valid && adv) begin
            dec_valid_d = 1'b0;
            state_d     = S_STALL;
        end else if (adv) begin
            dec_valid_d = 1'b0;
        end
    end

    // Single state/bundle register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            dec_valid_q <= 1'b0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            alu_op_q    <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_valid_q <= dec_valid_d;
            rd_q        <= rd_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            alu_op_q    <= alu_op_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign dec_valid     = dec_valid_q;
    assign dec_rd        = rd_q;
    assign dec_alu_op    = alu_op_q;
    assign dec_imm       = imm_q;
    assign dec_use_imm   = use_imm_q;
    assign dec_reg_write = reg_write_q;
    assign dec_mem_read  = mem_read_q;
    assign dec_mem_write = mem_write_q;
    assign dec_branch    = branch_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed testbench for instr_decode_stage: decode, load-use bubble,
// backpressure hold, illegal pulse, HALT and reset recovery.
module tb_instr_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  RA, RB;
    logic        dec_valid;
    logic        dec_ready;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_alu_op;
    logic [7:0]  dec_imm;
    logic        dec_use_imm, dec_reg_write, dec_mem_read, dec_mem_write, dec_branch;
    logic        halted, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    instr_decode_stage #(.IW(16), .DW(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .RA(RA), .RB(RB), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_alu_op(dec_alu_op),
        .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_reg_write(dec_reg_write),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_branch(dec_branch), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_in = 16'h0000; instr_valid = 1'b0; dec_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_RA", RA, 0);
        check("rst_RB", RB, 0);
        check("rst_rd", dec_rd, 0);
        check("rst_imm", dec_imm, 0);
        check("rst_ready", instr_ready, 1);
        next_cycle();

        // ADD r1 = r2 + r3: addresses appear in the same cycle
        instr_in = 16'h1298; instr_valid = 1'b1;
        @(negedge clk);
        check("add_RA", RA, 2);
        check("add_RB", RB, 3);
        check("add_ready", instr_ready, 1);
        next_cycle();

        // LOAD r1 <= M[r2+10]; ADD bundle now visible
        instr_in = 16'h628A;
        @(negedge clk);
        check("add_valid", dec_valid, 1);
        check("add_rd", dec_rd, 1);
        check("add_alu", dec_alu_op, 0);
        check("add_wr", dec_reg_write, 1);
        check("add_useimm", dec_use_imm, 0);
        check("ld_ready", instr_ready, 1);
        check("ld_RA", RA, 2);
        check("ld_RB", RB, 1);
        next_cycle();

        // ADD r2 = r3 + r1 depends on the load: hazard
        instr_in = 16'h14C8;
        @(negedge clk);
        check("ld_memrd", dec_mem_read, 1);
        check("ld_imm", dec_imm, 8'h0A);
        check("ld_useimm", dec_use_imm, 1);
        check("haz_ready", instr_ready, 0);
        check("haz_valid", dec_valid, 1);
        next_cycle();
        @(negedge clk);
        check("bubble_valid", dec_valid, 0);
        check("stall_ready", instr_ready, 0);
        next_cycle();
        @(negedge clk);
        check("reissue_ready", instr_ready, 1);
        check("reissue_RA", RA, 3);
        check("reissue_RB", RB, 1);
        next_cycle();

        // ADDI r5 = r0 + (-1)
        instr_in = 16'h5A3F;
        @(negedge clk);
        check("add2_valid", dec_valid, 1);
        check("add2_rd", dec_rd, 2);
        check("add2_memrd", dec_mem_read, 0);
        next_cycle();

        instr_in = 16'h1298;
        @(negedge clk);
        check("addi_imm", dec_imm, 8'hFF);
        check("addi_useimm", dec_use_imm, 1);
        check("addi_rd", dec_rd, 5);
        check("addi_wr", dec_reg_write, 1);
        next_cycle();

        // Backpressure for three cycles with SUB waiting
        dec_ready = 1'b0; instr_in = 16'h2A50;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ready", instr_ready, 0);
            check("hold_RA", RA, 2);
            check("hold_RB", RB, 3);
            check("hold_valid", dec_valid, 1);
            check("hold_rd", dec_rd, 1);
            next_cycle();
        end
        dec_ready = 1'b1;
        @(negedge clk);
        check("sub_ready", instr_ready, 1);
        check("sub_RA", RA, 1);
        check("sub_RB", RB, 2);
        next_cycle();

        // Undefined opcode 0xB
        instr_in = 16'hB000;
        @(negedge clk);
        check("sub_alu", dec_alu_op, 1);
        check("sub_rd", dec_rd, 5);
        next_cycle();

        instr_in = 16'h0000;
        @(negedge clk);
        check("ill_pulse", illegal, 1);
        check("ill_valid", dec_valid, 1);
        check("ill_wr", dec_reg_write, 0);
        next_cycle();

        // ADD with rd=0 must not write back
        instr_in = 16'h1098;
        @(negedge clk);
        check("ill_clear", illegal, 0);
        check("nop_valid", dec_valid, 1);
        check("nop_rd", dec_rd, 0);
        next_cycle();

        // BEQ r2, r3, +24
        instr_in = 16'h8098;
        @(negedge clk);
        check("rd0_wr", dec_reg_write, 0);
        check("rd0_valid", dec_valid, 1);
        next_cycle();

        instr_valid = 1'b0;
        @(negedge clk);
        check("beq_branch", dec_branch, 1);
        check("beq_alu", dec_alu_op, 1);
        check("beq_useimm", dec_use_imm, 0);
        check("beq_imm", dec_imm, 8'h18);
        next_cycle();
        @(negedge clk);
        check("idle_valid", dec_valid, 0);
        next_cycle();

        // HALT absorbs until reset
        instr_in = 16'hF000; instr_valid = 1'b1;
        @(negedge clk);
        check("halt_ready", instr_ready, 1);
        next_cycle();
        instr_in = 16'h1298;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halted", halted, 1);
            check("halt_noready", instr_ready, 0);
            check("halt_valid", dec_valid, 0);
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        check("rst2_halted", halted, 0);
        check("rst2_valid", dec_valid, 0);
        check("rst2_ready", instr_ready, 1);
        check("rst2_RA", RA, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
